// File: rtl/l2_sram_responder_pkg.sv
// l2_sram_responder_pkg: shared opcodes, widths and FSM encoding for the L2 SRAM responder.
package l2_sram_responder_pkg;
   localparam int MEM_L2TAG_BITS = 6;
   localparam int MEM_DATA_BITS  = 128;
   localparam int MEM_ADDR_BITS  = 12;
   localparam int BURST_LEN      = 4;
   localparam logic [1:0] MEM_RW_LINE_RD = 2'b00;
   localparam logic [1:0] MEM_RW_LINE_WR = 2'b01;
   localparam logic [1:0] MEM_RW_HTIF_RD = 2'b10;
   localparam logic [1:0] MEM_RW_HTIF_WR = 2'b11;
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_BURST = 2'd2
   } state_e;
endpackage

// File: rtl/l2_sram_responder_sram_1rw.sv
// sram_1rw: behavioural single-port array, 1-cycle registered read; drop-in slot for a hard macro.
module sram_1rw
   import l2_sram_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12,
   parameter int WIDTH      = MEM_DATA_BITS
)(
   input  logic                  clk,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o
);
   logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
   logic [WIDTH-1:0] rdata_q;
   always_ff @(posedge clk)
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         else rdata_q <= mem_q[addr_i];
      end
   assign rdata_o = rdata_q;
endmodule

// File: rtl/l2_sram_responder.sv
// l2_sram_responder: crossbar-side L2 responder; single/4-beat line reads and stores onto a 1RW SRAM.
module l2_sram_responder
   import l2_sram_responder_pkg::*;
#(
   parameter int ADDR_BITS  = MEM_ADDR_BITS,
   parameter int DEPTH_LOG2 = 12,
   parameter int DATA_BITS  = MEM_DATA_BITS,
   parameter int TAG_BITS   = MEM_L2TAG_BITS
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mem_req_val,
   output logic                 mem_req_rdy,
   input  logic [1:0]           mem_req_rw,
   input  logic [ADDR_BITS-1:0] mem_req_addr,
   input  logic [DATA_BITS-1:0] mem_req_data,
   input  logic [TAG_BITS-1:0]  mem_req_tag,
   output logic                 mem_resp_val,
   output logic                 mem_resp_nack,
   output logic [DATA_BITS-1:0] mem_resp_data,
   output logic [TAG_BITS-1:0]  mem_resp_tag,
   output logic                 proto_err
);
   state_e               state_q, state_d;
   logic [ADDR_BITS-3:0] line_q, line_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [TAG_BITS-1:0]  btag_q, btag_d, tag_q, rtag;
   logic                 rdy_q, val_q, nack_q, perr_q, perr_d;
   logic                 acc, rd, wr, in_rng;
   logic [ADDR_BITS-1:0] beat_addr;
   logic [DATA_BITS-1:0] ram_rdata;
   assign acc = mem_req_val && rdy_q;
   // Burst beats address the latched line with the counter as the low two bits, so they never leave the line.
   always_comb begin
      beat_addr = (state_q == ST_IDLE) ? (mem_req_rw[1] ? mem_req_addr : {mem_req_addr[ADDR_BITS-1:2], 2'b00})
                                       : {line_q, cnt_q};
      in_rng = (DEPTH_LOG2 >= ADDR_BITS) || ((beat_addr >> DEPTH_LOG2) == '0);
      rd = (state_q == ST_RD_BURST) || (state_q == ST_IDLE && acc && !mem_req_rw[0]);
      wr = acc && (state_q == ST_WR_BURST || mem_req_rw[0]);
      rtag = (state_q == ST_RD_BURST) ? btag_q : mem_req_tag;
      perr_d = perr_q || (state_q == ST_WR_BURST && acc && mem_req_rw != MEM_RW_LINE_WR);
      state_d = state_q;
      line_d = line_q;
      cnt_d = cnt_q;
      btag_d = btag_q;
      if (state_q == ST_IDLE) begin
         state_d = (acc && !mem_req_rw[1]) ? (mem_req_rw[0] ? ST_WR_BURST : ST_RD_BURST) : ST_IDLE;
         cnt_d = (acc && !mem_req_rw[1]) ? 2'd1 : 2'd0;
         line_d = acc ? mem_req_addr[ADDR_BITS-1:2] : line_q;
         btag_d = acc ? mem_req_tag : btag_q;
      end else if (state_q == ST_RD_BURST || acc) begin
         cnt_d = cnt_q + 2'd1;
         state_d = (cnt_q == 2'(BURST_LEN - 1)) ? ST_IDLE : state_q;
      end
   end
   sram_1rw #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(DATA_BITS)) u_sram (
      .clk     (clk),
      .en_i    ((rd || wr) && in_rng),
      .we_i    (wr),
      .addr_i  (beat_addr[DEPTH_LOG2-1:0]),
      .wdata_i (mem_req_data),
      .rdata_o (ram_rdata)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= ST_IDLE;
         line_q  <= '0;
         cnt_q   <= '0;
         btag_q  <= '0;
         tag_q   <= '0;
         rdy_q   <= 1'b0;
         val_q   <= 1'b0;
         nack_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         cnt_q   <= cnt_d;
         btag_q  <= btag_d;
         tag_q   <= rd ? rtag : tag_q;
         rdy_q   <= (state_d != ST_RD_BURST);
         val_q   <= rd;
         nack_q  <= rd && !in_rng;
         perr_q  <= perr_d;
      end
   // The array's read register is not reset, so data is forced to zero unless a good beat is presented.
   assign mem_resp_data = (val_q && !nack_q) ? ram_rdata : '0;
   assign mem_req_rdy   = rdy_q;
   assign mem_resp_val  = val_q;
   assign mem_resp_nack = nack_q;
   assign mem_resp_tag  = tag_q;
   assign proto_err     = perr_q;
endmodule

// File: tb/tb_l2_sram_responder.sv
// tb_l2_sram_responder: directed checks of l2_sram_responder with a 1K-beat array behind a 12-bit address.
module tb_l2_sram_responder;
   logic         clk = 1'b0, reset_n = 1'b0;
   logic         mem_req_val = 1'b0, mem_req_rdy;
   logic [1:0]   mem_req_rw = 2'b00;
   logic [11:0]  mem_req_addr = '0;
   logic [127:0] mem_req_data = '0;
   logic [5:0]   mem_req_tag = '0;
   logic         mem_resp_val, mem_resp_nack, proto_err;
   logic [127:0] mem_resp_data;
   logic [5:0]   mem_resp_tag;
   int           errors = 0, checks = 0;
   localparam logic [127:0] A5 = {16{8'hA5}};
   localparam logic [127:0] D0 = {4{32'hD000_0000}}, D1 = {4{32'hD111_1111}};
   localparam logic [127:0] D2 = {4{32'hD222_2222}}, D3 = {4{32'hD333_3333}};
   localparam logic [127:0] X0 = 128'h1000, X1 = 128'h1111, X2 = 128'h1222, BAD = {16{8'hEE}};
   localparam logic [127:0] P0 = 128'hF0, P1 = 128'hF1, P2 = 128'hF2, P3 = 128'hF3;

   l2_sram_responder #(.ADDR_BITS(12), .DEPTH_LOG2(10), .DATA_BITS(128), .TAG_BITS(6)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack), .mem_resp_data(mem_resp_data),
      .mem_resp_tag(mem_resp_tag), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one beat for a single clock edge, then deasserts val at the following falling edge.
   task automatic req(input logic [1:0] rw, input logic [11:0] addr, input logic [127:0] data, input logic [5:0] tag);
      mem_req_val = 1'b1;
      mem_req_rw = rw;
      mem_req_addr = addr;
      mem_req_data = data;
      mem_req_tag = tag;
      @(negedge clk);
      mem_req_val = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [127:0] data, input logic [5:0] rtag);
      chk({tag, "_val"}, mem_resp_val, 1'b1);
      chk({tag, "_nack"}, mem_resp_nack, 1'b0);
      chk({tag, "_data"}, mem_resp_data, data);
      chk({tag, "_tag"}, mem_resp_tag, rtag);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_rdy", mem_req_rdy, 1'b0);
      chk("rst_val", mem_resp_val, 1'b0);
      chk("rst_nack", mem_resp_nack, 1'b0);
      chk("rst_perr", proto_err, 1'b0);
      chk("rst_data", mem_resp_data, 128'h0);
      chk("rst_tag", mem_resp_tag, 6'h0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_rdy", mem_req_rdy, 1'b1);
      // single store then single read of the same address on the next cycle
      req(2'b11, 12'h010, A5, 6'd0);
      chk("store_no_resp", mem_resp_val, 1'b0);
      req(2'b10, 12'h010, '0, 6'd3);
      beat("single_rd", A5, 6'd3);
      @(negedge clk);
      chk("single_rd_one_beat", mem_resp_val, 1'b0);
      // line store with a 2-cycle gap before beat 2, then a misaligned line read
      req(2'b01, 12'h020, D0, 6'd7);
      req(2'b01, 12'h3FF, D1, 6'd9);
      repeat (2) @(negedge clk);
      chk("wr_gap_rdy", mem_req_rdy, 1'b1);
      req(2'b01, 12'h000, D2, 6'd0);
      req(2'b01, 12'h000, D3, 6'd0);
      chk("line_wr_no_perr", proto_err, 1'b0);
      req(2'b00, 12'h022, '0, 6'd5);
      chk("lrd_rdy1", mem_req_rdy, 1'b0);
      beat("lrd_b0", D0, 6'd5);
      @(negedge clk);
      chk("lrd_rdy2", mem_req_rdy, 1'b0);
      beat("lrd_b1", D1, 6'd5);
      @(negedge clk);
      chk("lrd_rdy3", mem_req_rdy, 1'b0);
      beat("lrd_b2", D2, 6'd5);
      @(negedge clk);
      chk("lrd_rdy4", mem_req_rdy, 1'b1);
      beat("lrd_b3", D3, 6'd5);
      @(negedge clk);
      chk("lrd_end", mem_resp_val, 1'b0);
      // back-to-back single reads sustain one beat per cycle
      req(2'b11, 12'h000, X0, 6'd0);
      req(2'b11, 12'h001, X1, 6'd0);
      req(2'b11, 12'h002, X2, 6'd0);
      req(2'b10, 12'h000, '0, 6'd1);
      beat("b2b_0", X0, 6'd1);
      req(2'b10, 12'h001, '0, 6'd2);
      beat("b2b_1", X1, 6'd2);
      req(2'b10, 12'h002, '0, 6'd3);
      beat("b2b_2", X2, 6'd3);
      // opcode violation inside a store burst
      req(2'b01, 12'h040, P0, 6'd0);
      req(2'b01, 12'h040, P1, 6'd0);
      chk("perr_before", proto_err, 1'b0);
      req(2'b10, 12'h123, P2, 6'd0);
      chk("perr_set", proto_err, 1'b1);
      chk("perr_beat_no_resp", mem_resp_val, 1'b0);
      req(2'b01, 12'h040, P3, 6'd0);
      chk("perr_sticky", proto_err, 1'b1);
      req(2'b00, 12'h041, '0, 6'd9);
      beat("perr_b0", P0, 6'd9);
      @(negedge clk);
      beat("perr_b1", P1, 6'd9);
      @(negedge clk);
      beat("perr_b2", P2, 6'd9);
      @(negedge clk);
      beat("perr_b3", P3, 6'd9);
      chk("perr_still", proto_err, 1'b1);
      // out-of-range: 0x400 is beyond a 1K-beat array
      req(2'b11, 12'h400, BAD, 6'd0);
      req(2'b10, 12'h400, '0, 6'd4);
      chk("oor_val", mem_resp_val, 1'b1);
      chk("oor_nack", mem_resp_nack, 1'b1);
      chk("oor_data", mem_resp_data, 128'h0);
      chk("oor_tag", mem_resp_tag, 6'd4);
      req(2'b10, 12'h000, '0, 6'd6);
      beat("oor_no_alias", X0, 6'd6);
      // reset in the middle of a line read
      req(2'b00, 12'h020, '0, 6'd2);
      beat("rst_b0", D0, 6'd2);
      @(negedge clk);
      beat("rst_b1", D1, 6'd2);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_val", mem_resp_val, 1'b0);
      chk("rst_async_rdy", mem_req_rdy, 1'b0);
      chk("rst_async_perr", proto_err, 1'b0);
      @(negedge clk);
      chk("rst_hold_val", mem_resp_val, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_rel_rdy", mem_req_rdy, 1'b1);
      chk("rst_rel_val", mem_resp_val, 1'b0);
      @(negedge clk);
      chk("rst_no_more_beats", mem_resp_val, 1'b0);
      req(2'b10, 12'h021, '0, 6'd1);
      beat("rst_keep_array", D1, 6'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/l2_sram_responder.md
Name: l2_sram_responder

Overview:
- Responder (slave) end of the L2-side memory request/response interface that the core/HTIF crossbar drives.
- Accepts crossbar requests on a two-bit opcode, performs single-port SRAM reads and writes, and returns tagged 128-bit response beats.
- Sits between the crossbar memory port and a behavioural single-port SRAM array.
- Intended as the parameterizable replacement L2 for multi-core test chips.

Parameters:
- ADDR_BITS, 12, width of mem_req_addr; unit is one 128-bit beat.
- DEPTH_LOG2, 12, log2 of array depth in beats. Must be <= ADDR_BITS.
- DATA_BITS, 128, beat width.
- TAG_BITS, 6, request/response tag width. Same value as MEM_L2TAG_BITS.

Ports:
- clk  in  1  single clock; all logic is posedge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req_val  in  1  request valid.
- mem_req_rdy  out  1  request ready. A beat is accepted when val&rdy.
- mem_req_rw  in  2  opcode. 00 = line read (4 beats), 01 = line store (4 beats), 10 = single read, 11 = single store.
- mem_req_addr  in  ADDR_BITS  beat address.
- mem_req_data  in  DATA_BITS  store data.
- mem_req_tag  in  TAG_BITS  request tag.
- mem_resp_val  out  1  response beat valid. No back-pressure.
- mem_resp_nack  out  1  qualifies mem_resp_val: address out of range, data invalid.
- mem_resp_data  out  DATA_BITS  read data.
- mem_resp_tag  out  TAG_BITS  tag of the originating request.
- proto_err  out  1  sticky; set on an opcode violation during a store burst.

Behaviour:
- Reset values (async, reset_n=0):
  - FSM = IDLE; beat counter = 0.
  - mem_req_rdy = 0 while reset is asserted, 1 from the first cycle after deassertion.
  - mem_resp_val, mem_resp_nack and proto_err = 0; mem_resp_data and mem_resp_tag = 0.
  - Array contents are not reset.
- Reset mid-operation aborts any burst immediately. No further response beats are emitted for it.
- FSM states: IDLE, RD_BURST, WR_BURST.
- IDLE, mem_req_rdy = 1. On acceptance:
  - 10: array read of addr in the accept cycle T. Response at T+1 with the accepted tag. Stay in IDLE, so back-to-back single reads sustain 1 beat/cycle.
  - 00: base = {addr[ADDR_BITS-1:2], 2'b00}; addr[1:0] is ignored. Read base+0 at T, then go to RD_BURST.
  - 11: write data to addr at T. No response. Stay in IDLE.
  - 01: base as for 00. Write beat 0 to base+0 at T, then go to WR_BURST with counter = 1.
- RD_BURST, mem_req_rdy = 0:
  - Reads base+1, base+2, base+3 at T+1..T+3, then returns to IDLE at T+4.
  - Response beats appear at T+1..T+4, one per cycle, all with the same tag, in address order.
- WR_BURST, mem_req_rdy = 1:
  - Each accepted beat writes base+counter; counter increments. Beat addr and tag are ignored.
  - After beat 3 is written, return to IDLE.
  - Idle cycles (val=0) between beats are permitted; the FSM waits indefinitely.
  - If a beat arrives with rw != 01, it is still written as store data and proto_err is set (sticky until reset).
- Response timing: read latency is exactly 1 cycle from array read. mem_resp_val is a registered output.
- Out-of-range addresses (addr >> DEPTH_LOG2 != 0, checked per beat):
  - Reads produce a beat with mem_resp_val=1, mem_resp_nack=1, data=0.
  - Out-of-range writes are dropped silently.
  - With default parameters, no address is out of range.
- Single port, one array access per cycle. A write at cycle T followed by a read of the same address at T+1 returns the new data.
- Response beats never overlap: the last burst beat (T+4) precedes the first response of the next request, which is accepted no earlier than T+4 and responds at T+5.
- Address arithmetic wraps within the ADDR_BITS field. base+3 never crosses a 4-beat boundary.

Decomposition:
- Shared package/header:
  - Opcode constants: MEM_RW_LINE_RD=2'b00, MEM_RW_LINE_WR=2'b01, MEM_RW_HTIF_RD=2'b10, MEM_RW_HTIF_WR=2'b11.
  - Burst length constant = 4.
  - FSM state encodings.
  - Tag/address/data width defines (MEM_L2TAG_BITS, MEM_DATA_BITS).
- Sub-module: sram_1rw. Behavioural single-port array with 1-cycle registered read, write enable, parameterized depth/width. Swappable for a hard macro.

Test Plan:
- Single store/read: HTIF store (11) addr 0x010 data 0xA5..A5, then single read (10) addr 0x010 tag 3 next cycle -> resp_val one cycle after read accept, data 0xA5..A5, tag 3, nack 0.
- Line store/read: line store (01) to base 0x020 with data D0..D3, including a 2-cycle val gap before beat 2; then line read (00) addr 0x022 tag 5 -> rdy low 3 cycles; 4 consecutive resp beats D0,D1,D2,D3 with tag 5.
- Back-to-back single reads: single reads of addr 0,1,2 on consecutive cycles with tags 1,2,3 -> three consecutive resp beats in order, no bubbles.
- Protocol violation: in WR_BURST after beat 1, present rw=10 -> beat is written to base+2, proto_err rises and stays 1; a later line read returns the written data at base+2.
- Out-of-range (DEPTH_LOG2=10, ADDR_BITS=12): single read addr 0x400 -> resp_val=1, nack=1, data 0; store to 0x400 leaves addr 0x000 unchanged.
- Reset mid-burst: assert reset_n=0 during RD_BURST after beat 1 -> resp_val drops asynchronously, no further beats; after release, rdy=1 next cycle and a single read returns the pre-reset array contents.
